dm_stage: RTL and testbench
===========================

Name: dm_stage

Overview:
- Data-memory access stage directly downstream of the function-processing (FP) stage in the DDP pipeline.
- Consumes the FP stage's outputs: LOAD_FLG, WRITE_EN, WRITE_DATA and the output packet.
- Executes LDM/STM against a local data memory, substitutes loaded data into LDM result packets, and passes all other packets through.
- Results are buffered in a small output FIFO so that downstream Ack stalls do not immediately back-pressure the FP stage.

Parameters:
- COLOR_W, 3, color field width
- GEN_W, 8, generation field width
- DEST_W, 8, destination field width
- DATA_W, 16, data field width
- ADDR_W, 8, data-memory address width; depth = 2**ADDR_W words of DATA_W
- FIFO_DEPTH, 2, output buffer entries; power of two, >=2
- PKT_W, COLOR_W+GEN_W+DEST_W+4+2+DATA_W, packet width

Ports:
- CP  input  1  clock; all state updates on rising edge
- MR_n  input  1  asynchronous active-low reset
- Send_in  input  1  FP stage presents a valid packet
- Ack_out  output  1  stage can accept a packet this cycle
- LOAD_FLG  input  1  packet is LDM
- WRITE_EN  input  1  packet is STM
- WRITE_DATA  input  DATA_W  store data
- PACKET_IN  input  PKT_W  {color, gen, dest, LR, BR, MF, CPY, C, Z, RESULTDATA}; RESULTDATA holds the computed address for LDM/STM
- Send_out  output  1  valid packet at head of output buffer
- Ack_in  input  1  downstream accepts the head packet
- PACKET_OUT  output  PKT_W  same field layout as PACKET_IN
- ERR  output  1  sticky: a packet arrived with LOAD_FLG and WRITE_EN both set

Behaviour:
- Reset (MR_n low, asynchronous):
  - FIFO emptied; Send_out=0, PACKET_OUT=0, ERR=0; Ack_out=1 once MR_n is high.
  - Data memory contents are not reset and are retained across reset.
  - A reset mid-operation drops all buffered packets.
- Accept: a packet is accepted on a rising CP with Send_in=1 and Ack_out=1.
  - Ack_out = (count < FIFO_DEPTH), derived combinationally from the registered count.
- Address: addr = RESULTDATA[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo the memory depth.
- STM (WRITE_EN=1, LOAD_FLG=0):
  - mem[addr] <= WRITE_DATA on the accept edge.
  - The packet is forwarded unchanged (RESULTDATA = address, C and Z unchanged).
- LDM (LOAD_FLG=1, WRITE_EN=0):
  - Memory is read combinationally at accept; the pushed packet carries RESULTDATA = mem[addr].
  - Z = ~|mem[addr]; C unchanged; all other fields unchanged.
- Neither flag set: the packet passes through bit-identical.
- Both flags set:
  - Treated as STM (write performed, packet forwarded unchanged).
  - ERR is set and stays set until reset.
- Ordering:
  - Packets leave in acceptance order.
  - Latency is 1 cycle: a packet accepted at edge N drives Send_out=1 after edge N when the FIFO was empty.
  - An STM accepted at edge N followed by an LDM to the same address at edge N+1 returns the stored data (write completes before the next read).
- Output:
  - PACKET_OUT is the FIFO head; it holds stable while Send_out=1 and Ack_in=0.
  - Pop occurs on a rising CP with Send_out=1 and Ack_in=1.
- Occupancy:
  - Same-edge push and pop: count unchanged, head advances, and the new entry is written at the tail.
  - When full, Ack_out=0, so no push is possible; a pop in that cycle drops count and re-raises Ack_out next cycle.
  - When empty, Send_out=0; a push and pop cannot happen on the same edge.
  - Read and write pointers are ADDR-style indices of log2(FIFO_DEPTH) bits that wrap naturally; count has log2(FIFO_DEPTH)+1 bits.
- Throughput: one packet per cycle sustained when Ack_in is held at 1.

Test Plan:
- Reset, then pass-through ADD packet (RESULTDATA=0x1234, C=1, Z=0, no flags) with Ack_in=1 -> next cycle Send_out=1 and PACKET_OUT is identical to the input; the following cycle Send_out=0.
- STM WRITE_DATA=0xBEEF, RESULTDATA=0x0105; then next cycle LDM RESULTDATA=0x0005 -> second output has RESULTDATA=0xBEEF and Z=0, showing address wrap and back-to-back ordering.
- STM 0x0000 to addr 0x10, then LDM addr 0x10 with input C=1 -> output RESULTDATA=0, Z=1, C=1.
- Ack_in=0 while presenting 3 packets on consecutive cycles (FIFO_DEPTH=2) -> Ack_out drops after 2 accepts and the third is held. Raise Ack_in -> all 3 emerge in order with no loss or duplication, and PACKET_OUT stays stable during the stall.
- Packet with LOAD_FLG=1 and WRITE_EN=1, WRITE_DATA=0x00AA, addr 7 -> ERR=1 and the packet is forwarded unchanged. A later LDM of addr 7 returns 0x00AA; ERR stays 1 until MR_n pulses low.
- STM 0x5555 to addr 3, fill the FIFO, assert MR_n low mid-stall -> Send_out=0 and Ack_out=1 immediately after release; a subsequent LDM of addr 3 still returns 0x5555.

Source files
------------

// File: rtl/dm_stage.sv
// Data-memory access stage: executes LDM/STM against a local memory and buffers
// result packets in a small FIFO ahead of the downstream handshake.
`timescale 1ns/1ps
module dm_stage #(
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned GEN_W      = 8,
  parameter int unsigned DEST_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PKT_W      = COLOR_W + GEN_W + DEST_W + 4 + 2 + DATA_W
) (
  input  logic             CP,
  input  logic             MR_n,
  input  logic             Send_in,
  output logic             Ack_out,
  input  logic             LOAD_FLG,
  input  logic             WRITE_EN,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic [PKT_W-1:0]  PACKET_IN,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic [PKT_W-1:0]  PACKET_OUT,
  output logic             ERR
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned Z_BIT     = DATA_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [PKT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              err_q;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [PKT_W-1:0]  push_pkt;

  assign Ack_out    = (count_q < CNT_W'(FIFO_DEPTH));
  assign Send_out   = (count_q != '0);
  assign PACKET_OUT = fifo_q[rd_ptr_q];
  assign ERR        = err_q;

  assign push    = Send_in & Ack_out;
  assign pop     = Send_out & Ack_in;
  assign addr    = PACKET_IN[ADDR_W-1:0];
  assign rd_data = mem[addr];

  // Only a pure LDM rewrites the packet; a both-flags packet behaves as STM.
  always_comb begin
    push_pkt = PACKET_IN;
    if (LOAD_FLG && !WRITE_EN) begin
      push_pkt[DATA_W-1:0] = rd_data;
      push_pkt[Z_BIT]      = ~|rd_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_pkt;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (push && LOAD_FLG && WRITE_EN) begin
        err_q <= 1'b1;
      end
    end
  end

  // Memory is deliberately outside the reset domain so its contents survive MR_n.
  always_ff @(posedge CP) begin
    if (push && WRITE_EN) begin
      mem[addr] <= WRITE_DATA;
    end
  end

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: queue/array reference model, per-cycle compare,
// directed literal scenarios and a randomized traffic phase.
`timescale 1ns/1ps
module tb_dm_stage;

  localparam int DEPTH = 2;
  localparam int PW    = 41;

  logic          CP = 1'b0;
  logic          MR_n = 1'b0;
  logic          Send_in = 1'b0;
  logic          Ack_out;
  logic          LOAD_FLG = 1'b0;
  logic          WRITE_EN = 1'b0;
  logic [15:0]   WRITE_DATA = '0;
  logic [PW-1:0] PACKET_IN = '0;
  logic          Send_out;
  logic          Ack_in = 1'b1;
  logic [PW-1:0] PACKET_OUT;
  logic          ERR;

  dm_stage dut (
    .CP(CP), .MR_n(MR_n), .Send_in(Send_in), .Ack_out(Ack_out),
    .LOAD_FLG(LOAD_FLG), .WRITE_EN(WRITE_EN), .WRITE_DATA(WRITE_DATA),
    .PACKET_IN(PACKET_IN), .Send_out(Send_out), .Ack_in(Ack_in),
    .PACKET_OUT(PACKET_OUT), .ERR(ERR)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [2:0] col, input logic [7:0] gen,
                                       input logic [7:0] dest, input logic [3:0] fl,
                                       input logic c, input logic z, input logic [15:0] d);
    return {col, gen, dest, fl, c, z, d};
  endfunction

  // Reference model: ordered queue of pending results plus a plain memory array.
  logic [PW-1:0] q[$];
  logic [15:0]   mem_m [256];
  logic          err_m = 1'b0;

  initial begin : model
    logic          do_pop, do_push;
    logic [PW-1:0] p;
    logic [7:0]    a;
    forever begin
      @(posedge CP or negedge MR_n);
      if (!MR_n) begin
        q.delete();
        err_m = 1'b0;
      end else begin
        do_pop  = (q.size() != 0) && Ack_in;
        do_push = Send_in && (q.size() < DEPTH);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          p = PACKET_IN;
          a = PACKET_IN[7:0];
          if (WRITE_EN) begin
            mem_m[a] = WRITE_DATA;
            if (LOAD_FLG) err_m = 1'b1;
          end else if (LOAD_FLG) begin
            p[15:0] = mem_m[a];
            p[16]   = (mem_m[a] == 16'h0000);
          end
          q.push_back(p);
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge CP);
      if (MR_n) begin
        check("send_out", 64'(Send_out), 64'(q.size() != 0));
        check("ack_out", 64'(Ack_out), 64'(q.size() < DEPTH));
        check("err", 64'(ERR), 64'(err_m));
        if (q.size() != 0) check("packet_out", 64'(PACKET_OUT), 64'(q[0]));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic ld, input logic we, input logic [15:0] wd,
                      input logic [PW-1:0] pkt);
    int n = 0;
    Send_in = 1'b1; LOAD_FLG = ld; WRITE_EN = we; WRITE_DATA = wd; PACKET_IN = pkt;
    while (!Ack_out && n < 100) begin
      @(negedge CP);
      n++;
    end
    check("ack_wait", 64'(Ack_out), 64'd1);
    @(posedge CP);
    @(negedge CP);
    Send_in = 1'b0; LOAD_FLG = 1'b0; WRITE_EN = 1'b0;
  endtask

  task automatic drain();
    Ack_in = 1'b1;
    repeat (3) @(negedge CP);
  endtask

  logic [PW-1:0] pa, pb, pc, exp_p;
  logic [63:0]   rnd;
  logic [15:0]   d;
  int            r;

  initial begin : main
    #3;
    check("rst_send_out", 64'(Send_out), 64'd0);
    check("rst_packet_out", 64'(PACKET_OUT), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    @(negedge CP); #2 MR_n = 1'b1;
    @(negedge CP);
    check("rst_ack_out", 64'(Ack_out), 64'd1);

    // Pass-through
    pa = mk(3'd5, 8'h12, 8'h34, 4'b1010, 1'b1, 1'b0, 16'h1234);
    send(1'b0, 1'b0, 16'h0, pa);
    check("pt_send_out", 64'(Send_out), 64'd1);
    check("pt_packet", 64'(PACKET_OUT), 64'(mk(3'd5, 8'h12, 8'h34, 4'b1010, 1'b1, 1'b0, 16'h1234)));
    @(negedge CP);
    check("pt_send_out_low", 64'(Send_out), 64'd0);

    // STM then LDM back-to-back, address wrap
    send(1'b0, 1'b1, 16'hBEEF, mk(3'd1, 8'h02, 8'h03, 4'b0000, 1'b0, 1'b0, 16'h0105));
    send(1'b1, 1'b0, 16'h0, mk(3'd1, 8'h02, 8'h03, 4'b0000, 1'b0, 1'b1, 16'h0005));
    check("ldm_wrap", 64'(PACKET_OUT), 64'(mk(3'd1, 8'h02, 8'h03, 4'b0000, 1'b0, 1'b0, 16'hBEEF)));
    drain();

    // Zero load sets Z, keeps C
    send(1'b0, 1'b1, 16'h0000, mk(3'd2, 8'h00, 8'h01, 4'b0001, 1'b0, 1'b0, 16'h0010));
    drain();
    send(1'b1, 1'b0, 16'h0, mk(3'd2, 8'h00, 8'h01, 4'b0001, 1'b1, 1'b0, 16'h0010));
    check("ldm_zero", 64'(PACKET_OUT), 64'(mk(3'd2, 8'h00, 8'h01, 4'b0001, 1'b1, 1'b1, 16'h0000)));
    drain();

    // Stall with three packets
    pa = mk(3'd3, 8'hA1, 8'h11, 4'b0100, 1'b0, 1'b0, 16'h1111);
    pb = mk(3'd4, 8'hA2, 8'h22, 4'b0010, 1'b1, 1'b0, 16'h2222);
    pc = mk(3'd6, 8'hA3, 8'h33, 4'b1000, 1'b0, 1'b1, 16'h3333);
    Ack_in = 1'b0; Send_in = 1'b1; PACKET_IN = pa;
    @(negedge CP); PACKET_IN = pb;
    @(negedge CP);
    check("stall_full", 64'(Ack_out), 64'd0);
    PACKET_IN = pc;
    @(negedge CP);
    check("stall_held", 64'(Ack_out), 64'd0);
    check("stall_head0", 64'(PACKET_OUT), 64'(pa));
    @(negedge CP);
    check("stall_head1", 64'(PACKET_OUT), 64'(pa));
    Ack_in = 1'b1;
    @(negedge CP);
    check("stall_out_b", 64'(PACKET_OUT), 64'(pb));
    check("stall_reack", 64'(Ack_out), 64'd1);
    @(negedge CP);
    check("stall_out_c", 64'(PACKET_OUT), 64'(pc));
    Send_in = 1'b0;
    @(negedge CP);
    check("stall_empty", 64'(Send_out), 64'd0);

    // Both flags: write happens, packet unchanged, ERR sticky
    exp_p = mk(3'd7, 8'h55, 8'h66, 4'b0011, 1'b1, 1'b0, 16'h0007);
    send(1'b1, 1'b1, 16'h00AA, exp_p);
    check("both_err", 64'(ERR), 64'd1);
    check("both_packet", 64'(PACKET_OUT), 64'(exp_p));
    drain();
    send(1'b1, 1'b0, 16'h0, mk(3'd0, 8'h01, 8'h02, 4'b0000, 1'b0, 1'b1, 16'h0007));
    check("both_readback", 64'(PACKET_OUT), 64'(mk(3'd0, 8'h01, 8'h02, 4'b0000, 1'b0, 1'b0, 16'h00AA)));
    check("err_sticky", 64'(ERR), 64'd1);
    drain();

    // Reset mid-stall; memory retained
    send(1'b0, 1'b1, 16'h5555, mk(3'd1, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 16'h0003));
    Ack_in = 1'b0;
    send(1'b0, 1'b0, 16'h0, mk(3'd2, 8'hFF, 8'hEE, 4'b1111, 1'b1, 1'b1, 16'hCAFE));
    check("rst_pre_full", 64'(Ack_out), 64'd0);
    #2 MR_n = 1'b0;
    #1;
    check("mid_rst_send_out", 64'(Send_out), 64'd0);
    check("mid_rst_packet", 64'(PACKET_OUT), 64'd0);
    check("mid_rst_err", 64'(ERR), 64'd0);
    @(negedge CP); #2 MR_n = 1'b1;
    @(negedge CP);
    check("post_rst_send_out", 64'(Send_out), 64'd0);
    check("post_rst_ack_out", 64'(Ack_out), 64'd1);
    Ack_in = 1'b1;
    send(1'b1, 1'b0, 16'h0, mk(3'd1, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1, 16'hFF03));
    check("mem_retained", 64'(PACKET_OUT), 64'(mk(3'd1, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 16'h5555)));
    drain();

    // Give every word a known value before random loads
    for (int a = 0; a < 256; a++) begin
      rnd = {$urandom, $urandom};
      send(1'b0, 1'b1, 16'($urandom), {rnd[PW-1:16], 8'($urandom), 8'(a)});
    end
    drain();

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      rnd = {$urandom, $urandom};
      d = ($urandom_range(0, 1) == 1) ? {8'($urandom), 8'($urandom_range(0, 7))} : 16'($urandom);
      Send_in    = ($urandom_range(0, 9) < 7);
      LOAD_FLG   = (r < 7) || (r == 19);
      WRITE_EN   = (r >= 7 && r < 13) || (r == 19);
      WRITE_DATA = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      PACKET_IN  = {rnd[PW-1:16], d};
      Ack_in     = ($urandom_range(0, 9) < 6);
      @(negedge CP);
    end
    Send_in = 1'b0; LOAD_FLG = 1'b0; WRITE_EN = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
